rs232_cmd_parser: RTL

- Packet controller that sits directly behind rs232_rx_ctrl.
- Sequences the raw byte stream (val/bits/error) into framed commands for the LCD command engine.
- Hunts for a sync byte, collects opcode, length and payload, verifies an XOR checksum, enforces an inter-byte timeout, then holds one validated command under a valid/ready handshake. The UART cannot be back-pressured, so bytes that arrive while a command is pending are dropped and flagged.

---
 rtl/rs232_pkg.sv | 28 ++
 rtl/rs232_cmd_buf.sv | 24 ++
 rtl/rs232_cmd_parser.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/rs232_pkg.sv
// rtl/rs232_pkg.sv - shared types and helpers for the RS-232 command parser
package rs232_pkg;

    localparam logic [7:0] DEFAULT_SYNC = 8'hA5;

    typedef enum logic [2:0] {
        HUNT,
        OP,
        LEN,
        PAYLOAD,
        CSUM,
        PEND
    } state_t;

    typedef struct packed {
        logic [7:0] op;
        logic [7:0] len;
    } cmd_t;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int log2x(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/rs232_cmd_buf.sv
// rtl/rs232_cmd_buf.sv - payload register file, one sync write port and one async read port
module rs232_cmd_buf #(
    parameter int DEPTH     = 16,
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [7:0]           wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [7:0]           rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rs232_cmd_parser.sv
// rtl/rs232_cmd_parser.sv - frames the UART byte stream into checksummed commands with valid/ready
module rs232_cmd_parser
    import rs232_pkg::*;
#(
    parameter logic [7:0] SYNC      = DEFAULT_SYNC,
    parameter int         MAX_LEN   = 16,
    parameter int         TIMEOUT   = 1000000,
    parameter int         LEN_BITS  = log2x(MAX_LEN + 1),
    parameter int         ADDR_BITS = log2x(MAX_LEN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_val,
    input  logic [7:0]           rx_bits,
    input  logic                 rx_error,
    output logic                 cmd_val,
    input  logic                 cmd_rdy,
    output logic [7:0]           cmd_op,
    output logic [LEN_BITS-1:0]  cmd_len,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [7:0]           rd_data,
    output logic                 err_frame,
    output logic                 err_csum,
    output logic                 err_len,
    output logic                 err_timeout,
    output logic                 err_overrun
);

    localparam int TMR_BITS = log2x(TIMEOUT);

    state_t                state;
    cmd_t                  cmd;
    logic [7:0]            csum;
    logic [LEN_BITS-1:0]   idx;
    logic [TMR_BITS-1:0]   tcnt;
    logic                  in_pkt;
    logic                  tmo;
    logic                  buf_we;

    assign in_pkt  = (state != HUNT) && (state != PEND);
    assign tmo     = (tcnt == TMR_BITS'(TIMEOUT - 1));
    assign buf_we  = (state == PAYLOAD) && rx_val && !rx_error;
    assign cmd_op  = cmd.op;
    assign cmd_len = cmd.len[LEN_BITS-1:0];

    rs232_cmd_buf #(
        .DEPTH     (MAX_LEN),
        .ADDR_BITS (ADDR_BITS)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (idx[ADDR_BITS-1:0]),
        .wdata (rx_bits),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= HUNT;
            cmd         <= '0;
            csum        <= '0;
            idx         <= '0;
            tcnt        <= '0;
            cmd_val     <= 1'b0;
            err_frame   <= 1'b0;
            err_csum    <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_frame   <= 1'b0;
            err_csum    <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;

            if (rx_val || rx_error || !in_pkt) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + TMR_BITS'(1);
            end

            case (state)
                HUNT: begin
                    if (rx_error) begin
                        err_frame <= 1'b1;
                    end else if (rx_val && rx_bits == SYNC) begin
                        state <= OP;
                    end
                end

                // The UART cannot be stalled: anything arriving here is lost.
                PEND: begin
                    if (rx_error) begin
                        err_frame <= 1'b1;
                    end
                    if (rx_val) begin
                        err_overrun <= 1'b1;
                    end
                    if (cmd_rdy) begin
                        cmd_val <= 1'b0;
                        state   <= HUNT;
                    end
                end

                default: begin
                    if (rx_error) begin
                        err_frame <= 1'b1;
                        state     <= HUNT;
                    end else if (rx_val) begin
                        case (state)
                            OP: begin
                                cmd.op <= rx_bits;
                                csum   <= rx_bits;
                                state  <= LEN;
                            end
                            LEN: begin
                                if (rx_bits > 8'(MAX_LEN)) begin
                                    err_len <= 1'b1;
                                    state   <= HUNT;
                                end else begin
                                    cmd.len <= rx_bits;
                                    csum    <= csum ^ rx_bits;
                                    idx     <= '0;
                                    state   <= (rx_bits == 8'd0) ? CSUM : PAYLOAD;
                                end
                            end
                            PAYLOAD: begin
                                csum <= csum ^ rx_bits;
                                idx  <= idx + LEN_BITS'(1);
                                if (8'(idx) == cmd.len - 8'd1) begin
                                    state <= CSUM;
                                end
                            end
                            CSUM: begin
                                if (rx_bits == csum) begin
                                    cmd_val <= 1'b1;
                                    state   <= PEND;
                                end else begin
                                    err_csum <= 1'b1;
                                    state    <= HUNT;
                                end
                            end
                            default: state <= HUNT;
                        endcase
                    end else if (tmo) begin
                        err_timeout <= 1'b1;
                        state       <= HUNT;
                        tcnt        <= '0;
                    end
                end
            endcase
        end
    end

endmodule
